// File: rtl/cb_param_chan.sv
// Connection block: straight channel passthrough plus NUM_IPIN programmable pin muxes
// whose selects come from a shift chain that is copied into the active selects on commit.
module cb_param_chan #(
    parameter int  CHAN_WIDTH = 19,
    parameter int  NUM_IPIN   = 7,
    parameter int  MUX_SIZE   = 8,
    parameter int  TAP_STRIDE = 6,
    localparam int SEL_W      = $clog2(MUX_SIZE),
    localparam int TOTAL      = NUM_IPIN * SEL_W,
    localparam int CNT_W      = $clog2(TOTAL + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    input  logic                  ccff_head,
    input  logic                  cfg_en,
    input  logic                  cfg_commit,
    output logic                  ccff_tail,
    output logic [CNT_W-1:0]      cfg_count,
    output logic                  cfg_full,
    output logic                  cfg_active,
    output logic                  cfg_err
);

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

    logic [TOTAL-1:0] chain_q, chain_d;
    logic [TOTAL-1:0] act_q, act_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;
    logic             err_q, err_d;
    logic             full_s;

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    assign full_s     = (count_q == TOTAL_C);
    assign cfg_full   = full_s;
    assign cfg_count  = count_q;
    assign cfg_active = active_q;
    assign cfg_err    = err_q;
    assign ccff_tail  = chain_q[TOTAL-1];

    // Pin muxes read only the committed selects, so shifting never disturbs the pins.
    for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
        logic [MUX_SIZE-1:0] mux_in_s;
        logic [SEL_W-1:0]    sel_s;

        for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
            localparam int TAP = (p + j * TAP_STRIDE) % CHAN_WIDTH;
            assign mux_in_s[2*j]   = chanx_left_in[TAP];
            assign mux_in_s[2*j+1] = chanx_right_in[TAP];
        end

        assign sel_s       = act_q[p*SEL_W +: SEL_W];
        assign ipin_out[p] = (active_q && (int'(sel_s) < MUX_SIZE)) ? mux_in_s[sel_s] : 1'b0;
    end

    // Next-state for chain, shift counter and commit bookkeeping.
    always_comb begin
        chain_d  = chain_q;
        act_d    = act_q;
        count_d  = count_q;
        active_d = active_q;
        err_d    = err_q;

        if (cfg_en) begin
            chain_d    = chain_q << 1;
            chain_d[0] = ccff_head;
            if (count_q != TOTAL_C) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q;
            end
        end else begin
            chain_d = chain_q;
        end

        // Commit captures the pre-shift chain; an incomplete chain is rejected and flagged.
        if (cfg_commit) begin
            if (full_s) begin
                act_d    = chain_q;
                active_d = 1'b1;
                count_d  = CNT_W'(cfg_en);
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous reset taking priority over shift and commit.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            chain_q  <= '0;
            act_q    <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            chain_q  <= chain_d;
            act_q    <= act_d;
            count_q  <= count_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

endmodule
